// File: rtl/codificacao.sv
// codificacao: sequential RISC-V instruction encoder; builds 32-bit words
// from decoded fields and writes them to instruction memory.
// Ports:
// - clk, rst_n: clock and asynchronous active-low reset.
// - in_valid/in_ready: field-set handshake.
// - tipo, opcode, rd, rs1, rs2, funct3, funct7, immediate, negativo:
//   decoded instruction fields.
// - mem_we, mem_addr, mem_wdata: one-cycle write port to memory.
// - err, err_code: rejection pulse and held error code.
// - count, full: words written so far, capacity reached.
module codificacao #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          MAX_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  tipo,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [11:0] immediate,
  input  logic        negativo,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [6:0]  count,
  output logic        full
);

  typedef enum logic [1:0] {
    IDLE,
    ENCODE,
    WRITE
  } state_t;

  state_t      state_q, state_d;

  logic [2:0]  tipo_q;
  logic [6:0]  op_q;
  logic [4:0]  rd_q;
  logic [4:0]  rs1_q;
  logic [4:0]  rs2_q;
  logic [2:0]  f3_q;
  logic [6:0]  f7_q;
  logic [11:0] imm_q;
  logic        neg_q;
  logic        load;

  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] ptr_q, ptr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;
  logic [6:0]  count_q, count_d;

  logic [11:0] imm12;
  logic [12:0] off13;
  logic [31:0] word;
  logic [1:0]  chk;

  assign full      = (count_q == 7'(MAX_WORDS));
  assign in_ready  = (state_q == IDLE) && !full;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign err       = err_q;
  assign err_code  = code_q;
  assign count     = count_q;

  // Signed immediates are carried as magnitude + sign.
  assign imm12 = neg_q ? (~imm_q + 12'd1) : imm_q;
  assign off13 = neg_q ? (~{1'b0, imm_q} + 13'd1)
                       : {1'b0, imm_q};

  always_comb begin
    word = 32'h0;
    chk  = 2'b00;
    unique case (tipo_q)
      3'b000: begin
        word = {imm_q, rs1_q, f3_q, rd_q, op_q};
      end
      3'b001: begin
        word = {imm12, rs1_q, f3_q, rd_q, op_q};
        if (neg_q ? (imm_q > 12'd2048)
                  : (imm_q > 12'd2047))
          chk = 2'b11;
      end
      3'b010: begin
        word = {imm_q[11:5], rs2_q, rs1_q,
                f3_q, imm_q[4:0], op_q};
      end
      3'b011: begin
        word = {f7_q, rs2_q, rs1_q,
                f3_q, rd_q, op_q};
      end
      3'b110: begin
        word = {off13[12], off13[10:5], rs2_q,
                rs1_q, f3_q, off13[4:1],
                off13[11], op_q};
        if (imm_q[0] || (imm_q > 12'd4094))
          chk = 2'b11;
      end
      default: begin
        word = 32'h0;
      end
    endcase
    // Priority: bad tipo, then opcode class, then immediate.
    if (!(tipo_q inside {3'b000, 3'b001, 3'b010,
                         3'b011, 3'b110}))
      chk = 2'b01;
    else if (op_q[6:4] != tipo_q)
      chk = 2'b10;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    we_d    = 1'b0;
    err_d   = 1'b0;
    addr_d  = addr_q;
    ptr_d   = ptr_q;
    wdata_d = wdata_q;
    code_d  = code_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          load    = 1'b1;
          code_d  = 2'b00;
          state_d = ENCODE;
        end
      end
      ENCODE: begin
        if (chk != 2'b00) begin
          err_d   = 1'b1;
          code_d  = chk;
          state_d = IDLE;
        end else begin
          we_d    = 1'b1;
          wdata_d = word;
          addr_d  = ptr_q;
          state_d = WRITE;
        end
      end
      WRITE: begin
        ptr_d   = ptr_q + 32'd4;
        count_d = count_q + 7'd1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      ptr_q   <= BASE_ADDR;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
      count_q <= 7'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      ptr_q   <= ptr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      code_q  <= code_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tipo_q <= 3'b000;
      op_q   <= 7'h0;
      rd_q   <= 5'h0;
      rs1_q  <= 5'h0;
      rs2_q  <= 5'h0;
      f3_q   <= 3'h0;
      f7_q   <= 7'h0;
      imm_q  <= 12'h0;
      neg_q  <= 1'b0;
    end else if (load) begin
      tipo_q <= tipo;
      op_q   <= opcode;
      rd_q   <= rd;
      rs1_q  <= rs1;
      rs2_q  <= rs2;
      f3_q   <= funct3;
      f7_q   <= funct7;
      imm_q  <= immediate;
      neg_q  <= negativo;
    end
  end

endmodule

// File: tb/tb_codificacao.sv
// tb_codificacao: directed self-checking bench for codificacao.
// Instance a uses defaults; instance b has base 0x100 and 2-word capacity.
module tb_codificacao;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        va = 1'b0;
  logic        vb = 1'b0;
  logic [2:0]  tipo = '0;
  logic [6:0]  opcode = '0;
  logic [4:0]  rd = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [11:0] immediate = '0;
  logic        negativo = 1'b0;

  logic        rdy_a, we_a, err_a, full_a;
  logic [31:0] addr_a, data_a;
  logic [1:0]  code_a;
  logic [6:0]  cnt_a;
  logic        rdy_b, we_b, err_b, full_b;
  logic [31:0] addr_b, data_b;
  logic [1:0]  code_b;
  logic [6:0]  cnt_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  codificacao u_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(va), .in_ready(rdy_a),
    .tipo(tipo), .opcode(opcode), .rd(rd),
    .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .immediate(immediate),
    .negativo(negativo),
    .mem_we(we_a), .mem_addr(addr_a),
    .mem_wdata(data_a), .err(err_a),
    .err_code(code_a), .count(cnt_a),
    .full(full_a)
  );

  codificacao #(
    .BASE_ADDR(32'h100),
    .MAX_WORDS(2)
  ) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(vb), .in_ready(rdy_b),
    .tipo(tipo), .opcode(opcode), .rd(rd),
    .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .immediate(immediate),
    .negativo(negativo),
    .mem_we(we_b), .mem_addr(addr_b),
    .mem_wdata(data_b), .err(err_b),
    .err_code(code_b), .count(cnt_b),
    .full(full_b)
  );

  task automatic set_f(
    input logic [2:0] t, input logic [6:0] op,
    input logic [4:0] d, input logic [4:0] s1,
    input logic [4:0] s2, input logic [2:0] f3,
    input logic [6:0] f7, input logic [11:0] im,
    input logic ng);
    tipo = t; opcode = op; rd = d;
    rs1 = s1; rs2 = s2; funct3 = f3;
    funct7 = f7; immediate = im; negativo = ng;
  endtask

  // Drives one field set; returns 1ns after the edge following accept.
  task automatic send(input bit b);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    if (b) vb = 1'b1;
    else va = 1'b1;
    for (int i = 0; i < 10 && !ok; i++) begin
      if (b ? rdy_b : rdy_a) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout in_ready stayed 0, required 1");
      va = 1'b0; vb = 1'b0;
    end else begin
      @(posedge clk); #1;
      va = 1'b0; vb = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (we_a !== 1'b0) begin n_bad++; $display("FAIL rst_we got %b want 0", we_a); end
    n_cmp++; if (addr_a !== 32'h0) begin n_bad++; $display("FAIL rst_addr got %h want 0", addr_a); end
    n_cmp++; if (data_a !== 32'h0) begin n_bad++; $display("FAIL rst_data got %h want 0", data_a); end
    n_cmp++; if (err_a !== 1'b0 || code_a !== 2'b00) begin n_bad++; $display("FAIL rst_err got %b/%b want 0/00", err_a, code_a); end
    n_cmp++; if (cnt_a !== 7'd0 || full_a !== 1'b0) begin n_bad++; $display("FAIL rst_count got %0d/%b want 0/0", cnt_a, full_a); end
    n_cmp++; if (rdy_a !== 1'b1) begin n_bad++; $display("FAIL rst_ready got %b want 1", rdy_a); end
    n_cmp++; if (addr_b !== 32'h100) begin n_bad++; $display("FAIL rst_addr_b got %h want 100", addr_b); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_addi;
    set_f(3'b001, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'd5, 1'b0);
    send(1'b0);
    n_cmp++; if (we_a !== 1'b1) begin n_bad++; $display("FAIL addi_we got %b want 1", we_a); end
    n_cmp++; if (addr_a !== 32'h0) begin n_bad++; $display("FAIL addi_addr got %h want 0", addr_a); end
    n_cmp++; if (data_a !== 32'h00500093) begin n_bad++; $display("FAIL addi_data got %h want 00500093", data_a); end
    n_cmp++; if (rdy_a !== 1'b0) begin n_bad++; $display("FAIL addi_busy got %b want 0", rdy_a); end
    @(posedge clk); #1;
    n_cmp++; if (we_a !== 1'b0) begin n_bad++; $display("FAIL addi_we_drop got %b want 0", we_a); end
    n_cmp++; if (cnt_a !== 7'd1 || rdy_a !== 1'b1) begin n_bad++; $display("FAIL addi_cnt got %0d/%b want 1/1", cnt_a, rdy_a); end
    set_f(3'b001, 7'b0010011, 5'd2, 5'd1, 5'd0, 3'd0, 7'd0, 12'd1, 1'b1);
    send(1'b0);
    n_cmp++; if (addr_a !== 32'h4 || we_a !== 1'b1) begin n_bad++; $display("FAIL addi2_addr got %h/%b want 4/1", addr_a, we_a); end
    n_cmp++; if (data_a !== 32'hFFF08113) begin n_bad++; $display("FAIL addi2_data got %h want FFF08113", data_a); end
    @(posedge clk); #1;
    n_cmp++; if (cnt_a !== 7'd2) begin n_bad++; $display("FAIL addi2_cnt got %0d want 2", cnt_a); end
  endtask

  task automatic test_store_r;
    set_f(3'b010, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 12'd8, 1'b0);
    send(1'b0);
    n_cmp++; if (addr_a !== 32'h8 || data_a !== 32'h0020A423) begin n_bad++; $display("FAIL sw got %h@%h want 0020A423@8", data_a, addr_a); end
    @(posedge clk); #1;
    set_f(3'b011, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 12'd0, 1'b0);
    send(1'b0);
    n_cmp++; if (addr_a !== 32'hC || data_a !== 32'h002081B3) begin n_bad++; $display("FAIL add got %h@%h want 002081B3@c", data_a, addr_a); end
    @(posedge clk); #1;
    n_cmp++; if (cnt_a !== 7'd4) begin n_bad++; $display("FAIL add_cnt got %0d want 4", cnt_a); end
  endtask

  task automatic test_branch;
    set_f(3'b110, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 12'd8, 1'b1);
    send(1'b0);
    n_cmp++; if (addr_a !== 32'h10 || data_a !== 32'hFE208CE3) begin n_bad++; $display("FAIL beq got %h@%h want FE208CE3@10", data_a, addr_a); end
    @(posedge clk); #1;
    set_f(3'b110, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 12'd7, 1'b1);
    send(1'b0);
    n_cmp++; if (err_a !== 1'b1 || code_a !== 2'b11) begin n_bad++; $display("FAIL beq_odd_err got %b/%b want 1/11", err_a, code_a); end
    n_cmp++; if (we_a !== 1'b0 || addr_a !== 32'h10) begin n_bad++; $display("FAIL beq_odd_nowrite got %b/%h want 0/10", we_a, addr_a); end
    n_cmp++; if (rdy_a !== 1'b1) begin n_bad++; $display("FAIL beq_odd_ready got %b want 1", rdy_a); end
    @(posedge clk); #1;
    n_cmp++; if (err_a !== 1'b0 || code_a !== 2'b11) begin n_bad++; $display("FAIL beq_odd_hold got %b/%b want 0/11", err_a, code_a); end
    n_cmp++; if (cnt_a !== 7'd5) begin n_bad++; $display("FAIL beq_odd_cnt got %0d want 5", cnt_a); end
  endtask

  task automatic test_errors;
    set_f(3'b111, 7'b1110011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 1'b0);
    send(1'b0);
    n_cmp++; if (err_a !== 1'b1 || code_a !== 2'b01) begin n_bad++; $display("FAIL tipo_err got %b/%b want 1/01", err_a, code_a); end
    set_f(3'b001, 7'b0110011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'd1, 1'b0);
    send(1'b0);
    n_cmp++; if (err_a !== 1'b1 || code_a !== 2'b10) begin n_bad++; $display("FAIL op_err got %b/%b want 1/10", err_a, code_a); end
    set_f(3'b001, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'd2048, 1'b0);
    send(1'b0);
    n_cmp++; if (err_a !== 1'b1 || code_a !== 2'b11 || we_a !== 1'b0) begin n_bad++; $display("FAIL imm2048_pos got %b/%b/%b want 1/11/0", err_a, code_a, we_a); end
    set_f(3'b001, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'd2048, 1'b1);
    send(1'b0);
    n_cmp++; if (we_a !== 1'b1 || err_a !== 1'b0 || code_a !== 2'b00) begin n_bad++; $display("FAIL imm2048_neg got %b/%b/%b want 1/0/00", we_a, err_a, code_a); end
    n_cmp++; if (data_a !== 32'h80000093 || addr_a !== 32'h14) begin n_bad++; $display("FAIL imm2048_data got %h@%h want 80000093@14", data_a, addr_a); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int strobes;
    strobes = 0;
    set_f(3'b001, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'd5, 1'b0);
    @(negedge clk);
    va = 1'b1;
    repeat (9) begin
      @(posedge clk); #1;
      if (we_a) strobes++;
    end
    va = 1'b0;
    n_cmp++; if (strobes !== 3) begin n_bad++; $display("FAIL b2b_strobes got %0d want 3", strobes); end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (cnt_a !== 7'd9 || addr_a !== 32'h20) begin n_bad++; $display("FAIL b2b_cnt got %0d@%h want 9@20", cnt_a, addr_a); end
  endtask

  task automatic test_full;
    int strobes;
    set_f(3'b001, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'd5, 1'b0);
    send(1'b1);
    n_cmp++; if (we_b !== 1'b1 || addr_b !== 32'h100) begin n_bad++; $display("FAIL full_w1 got %b@%h want 1@100", we_b, addr_b); end
    @(posedge clk); #1;
    n_cmp++; if (full_b !== 1'b0 || cnt_b !== 7'd1) begin n_bad++; $display("FAIL full_early got %b/%0d want 0/1", full_b, cnt_b); end
    send(1'b1);
    n_cmp++; if (we_b !== 1'b1 || addr_b !== 32'h104) begin n_bad++; $display("FAIL full_w2 got %b@%h want 1@104", we_b, addr_b); end
    @(posedge clk); #1;
    n_cmp++; if (full_b !== 1'b1 || rdy_b !== 1'b0 || cnt_b !== 7'd2) begin n_bad++; $display("FAIL full_set got %b/%b/%0d want 1/0/2", full_b, rdy_b, cnt_b); end
    strobes = 0;
    @(negedge clk);
    vb = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (we_b) strobes++;
    end
    vb = 1'b0;
    n_cmp++; if (strobes !== 0 || cnt_b !== 7'd2) begin n_bad++; $display("FAIL full_block got %0d/%0d want 0/2", strobes, cnt_b); end
  endtask

  task automatic test_reset_midop;
    set_f(3'b001, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'd5, 1'b0);
    send(1'b0);
    n_cmp++; if (we_a !== 1'b1) begin n_bad++; $display("FAIL mid_pre_we got %b want 1", we_a); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (we_a !== 1'b0 || cnt_a !== 7'd0 || addr_a !== 32'h0) begin n_bad++; $display("FAIL mid_rst got %b/%0d/%h want 0/0/0", we_a, cnt_a, addr_a); end
    n_cmp++; if (data_a !== 32'h0 || full_b !== 1'b0) begin n_bad++; $display("FAIL mid_rst_data got %h/%b want 0/0", data_a, full_b); end
    @(negedge clk);
    rst_n = 1'b1;
    send(1'b0);
    n_cmp++; if (we_a !== 1'b1 || addr_a !== 32'h0 || data_a !== 32'h00500093) begin n_bad++; $display("FAIL mid_after got %b/%h/%h want 1/0/00500093", we_a, addr_a, data_a); end
    @(posedge clk); #1;
    n_cmp++; if (cnt_a !== 7'd1) begin n_bad++; $display("FAIL mid_cnt got %0d want 1", cnt_a); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_addi();
    test_store_r();
    test_branch();
    test_errors();
    test_back_to_back();
    test_full();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/codificacao.md
# codificacao

Sequential RISC-V instruction encoder: accepts decoded instruction fields (the same field set and `tipo`/`negativo` conventions the decoder produces) over a valid/ready handshake. It assembles the 32-bit machine word and writes it into instruction memory at an auto-incrementing word address. It sits between the test/program loader and instruction memory, so programs can be built from fields and round-tripped through the decoder.

## Interface
- `BASE_ADDR`, 0: byte address of the first written word.
- `MAX_WORDS`, 64: capacity in words; writes stop at this count.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: field set valid.
- `in_ready` out 1: encoder can accept; `(state==IDLE) && !full`.
- `tipo` in 3: format, 000 I-load, 001 I-arith, 010 S, 011 R, 110 SB.
- `opcode` in 7, `rd` in 5, `rs1` in 5, `rs2` in 5, `funct3` in 3, `funct7` in 7: raw fields.
- `immediate` in 12: raw field for tipo 000/010; magnitude for 001/110.
- `negativo` in 1: immediate is negative (tipo 001/110 only; ignored otherwise).
- `mem_we` out 1: one-cycle write strobe.
- `mem_addr` out 32: byte address of current write.
- `mem_wdata` out 32: encoded instruction.
- `err` out 1: one-cycle pulse, field set rejected.
- `err_code` out 2: 01 bad tipo, 10 `opcode[6:4]!=tipo`, 11 immediate out of range/misaligned; held until next accept.
- `count` out 7: words written.
- `full` out 1: `count==MAX_WORDS`.

## Operation
- FSM: IDLE, ENCODE, WRITE.
- IDLE: on `in_valid && in_ready`, register all fields, clear `err_code`, go ENCODE.
- ENCODE: check, in priority order: tipo not in {000,001,010,011,110} -> 01; `opcode[6:4]!=tipo` -> 10; immediate rule -> 11. On error: pulse `err`, set `err_code`, go IDLE, no write, address/count unchanged. Otherwise register `mem_wdata`, `mem_addr`, assert `mem_we`, go WRITE.
- WRITE: deassert `mem_we`, `mem_addr` next = +4, `count`+1, go IDLE.
- Encoding, with opcode always in [6:0]:
  - 000: `{immediate, rs1, funct3, rd, opcode}`.
  - 001: imm12 = `negativo ? -immediate : immediate`, then as 000. Range is magnitude <=2047 when positive and <=2048 when negative (2048 -> 0x800); otherwise error 11.
  - 010: `{immediate[11:5], rs2, rs1, funct3, immediate[4:0], opcode}`.
  - 011: `{funct7, rs2, rs1, funct3, rd, opcode}`.
  - 110: off13 = `negativo ? -{1'b0,immediate} : {1'b0,immediate}`. Word = `{off[12], off[10:5], rs2, rs1, funct3, off[4:1], off[11], opcode}`. Error 11 if `immediate[0]==1` or `immediate>4094`.
- Fields unused by a format are ignored.

## Timing
- Reset values: state IDLE, `mem_we` 0, `mem_addr` BASE_ADDR, `mem_wdata` 0, `err` 0, `err_code` 00, `count` 0, `full` 0. `in_ready` is 1 after reset.
- Accept at edge k. `mem_we`, `mem_addr` and `mem_wdata` are valid from edge k+1 to edge k+2. `in_ready` is high again after edge k+2.
- Error accepted at edge k: `err` is high from edge k+1 to edge k+2, and `in_ready` is high after edge k+1.
- Throughput is 1 instruction per 3 cycles. `in_ready` is low in ENCODE/WRITE, and `in_valid` there is ignored.
- `mem_addr` holds the last written address until the next write, then advances by 4. There is no wrap.
- Full: `full` rises at the WRITE->IDLE edge of the MAX_WORDS-th write, and `in_ready` stays 0 until reset.
- `rst_n` asserted mid-operation (ENCODE/WRITE) aborts immediately. No strobe completes, and all outputs take their reset values asynchronously.

## Test plan
- addi x1,x0,5 (tipo 001, opcode 0010011, rd 1, imm 5, neg 0) -> `mem_we` at k+1, addr 0, data 0x00500093; then addi x2,x1,-1 (imm 1, neg 1) -> addr 4, data 0xFFF08113, count 2.
- sw x2,8(x1) (tipo 010, opcode 0100011, funct3 010, imm 8) -> 0x0020A423; add x3,x1,x2 (tipo 011, opcode 0110011) -> 0x002081B3.
- beq x1,x2,-8 (tipo 110, opcode 1100011, imm 8, neg 1) -> 0xFE208CE3. With imm 7 -> `err` pulse, err_code 11, no `mem_we`, addr unchanged.
- tipo 111 -> err_code 01. Tipo 001 with opcode 0110011 -> err_code 10. Tipo 001 with imm 2048, neg 0 -> 11; with imm 2048, neg 1 -> data imm field 0x800, no error.
- MAX_WORDS=2: two valid writes -> `full`=1, `in_ready`=0, and a third `in_valid` yields no strobe. `in_valid` held continuously -> exactly one accept per 3 cycles.
- `rst_n` low during WRITE -> `mem_we` 0 immediately, `count` 0, `mem_addr` BASE_ADDR; the next accept writes to BASE_ADDR.
